cnt_arb_ctrl: RTL
=================

CNT_ARB_CTRL -- requirements
Module: cnt_arb_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 4, counter and argument width.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port req  input  2  per-requester command request; bit i is requester i.
REQ-005 SHALL provide ports op0, op1  input  2 each  command code: 00 LOAD, 01 CLEAR, 10 PRESET, 11 COUNT.
REQ-006 SHALL provide ports arg0, arg1  input  CNT_W each  LOAD value or COUNT length.
REQ-007 SHALL provide port ack  output  2  one-cycle completion pulse per requester.
REQ-008 SHALL provide port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL provide port cnt_q  output  CNT_W  current shared counter value.
REQ-010 SHALL provide port wrap  output  1  one-cycle pulse when an increment takes cnt_q from all-ones to zero.

Function
REQ-011 SHALL implement states IDLE, EXEC, COUNT.
REQ-012 In IDLE with any eligible req bit high, SHALL grant one requester, latch its op/arg and enter EXEC on the next edge.
REQ-013 Arbitration SHALL be round-robin: when both request, the requester not granted last wins; after each grant, priority passes to the other requester.
REQ-014 A requester whose ack is high in the current cycle SHALL be ineligible for arbitration in that cycle.
REQ-015 Latched op/arg SHALL be used for the whole operation; later changes on op/arg/req SHALL be ignored.
REQ-016 EXEC with LOAD: cnt_q <= latched arg; ack asserted in the next cycle; return to IDLE.
REQ-017 EXEC with CLEAR: cnt_q <= 0; ack asserted in the next cycle; return to IDLE.
REQ-018 EXEC with PRESET: cnt_q <= all ones; ack asserted in the next cycle; return to IDLE.
REQ-019 EXEC with COUNT and arg = 0: cnt_q unchanged; ack asserted in the next cycle; return to IDLE.
REQ-020 EXEC with COUNT and arg = N > 0: load remaining <= N, enter COUNT; cnt_q unchanged in EXEC.
REQ-021 Each COUNT cycle SHALL perform cnt_q <= cnt_q + 1 modulo 2^CNT_W and remaining <= remaining - 1; when remaining = 1, ack is asserted in the next cycle and the state returns to IDLE (exactly N increments).
REQ-022 Latency: req sampled high in IDLE at cycle t -> ack and updated cnt_q visible at cycle t+2 for LOAD/CLEAR/PRESET/zero-COUNT, and at t+2+N-1 for COUNT N.
REQ-023 wrap SHALL pulse in the cycle after the increment that yields zero; LOAD/CLEAR/PRESET SHALL never assert wrap.
REQ-024 cnt_q SHALL hold its value in all cycles with no operation in effect.
REQ-025 ack SHALL be registered, one-hot or zero, and never high for a requester that was not granted.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, cnt_q 0, remaining 0, ack 0, wrap 0, busy 0, and priority to requester 0.
REQ-027 Reset during EXEC or COUNT SHALL abandon the operation without any ack.
REQ-028 rst_n release SHALL be synchronous to clk, guaranteed externally; first arbitration occurs on the first edge after release.

Structure
REQ-029 Shared package cnt_ctrl_pkg SHALL hold the op encodings, the state enum and the default CNT_W.
REQ-030 The counter register SHALL be sub-module cnt_reg: synchronous controls pre, clr, ld, inc with priority pre > clr > ld > inc, async active-low reset to 0, and a wrap output.
REQ-031 cnt_arb_ctrl SHALL contain the arbiter, FSM and remaining counter only, and SHALL drive cnt_reg's controls.

Verification
REQ-032 Reset, req0 LOAD arg 0x9 -> cnt_q=0x9 and ack=01 exactly at t+2; busy high for one cycle.
REQ-033 req0 PRESET, then req1 COUNT arg 2 -> cnt_q 0xF, 0x0, 0x1; wrap pulses once; ack=10 after the second increment.
REQ-034 Both requesters hold req continuously (req0 CLEAR, req1 LOAD 0x5) -> grants alternate 0,1,0,1; no back-to-back grant to the same requester.
REQ-035 COUNT arg 0 -> ack at t+2, cnt_q unchanged, wrap low.
REQ-036 rst_n low mid-COUNT arg 0xA after 3 increments -> cnt_q=0 asynchronously, no ack, next req0 LOAD 0x3 completes normally.
REQ-037 op/arg changed while busy -> latched command executes unchanged (e.g. LOAD 0x4 still yields 0x4).

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the arbitrated counter controller: command
// encodings, controller state enum and the default counter width.
package cnt_ctrl_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_COUNT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_COUNT = 2'b10
    } state_e;

endpackage

// File: rtl/cnt_reg.sv
// Shared counter register. Synchronous controls with priority
// pre > clr > ld > inc; wrap pulses the cycle after an increment rolls
// the value over from all-ones to zero.
module cnt_reg
    import cnt_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] cnt_q,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;

    // Counter update; only an increment can raise wrap, every other cycle clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (pre) begin
                r_cnt <= '1;
            end else if (clr) begin
                r_cnt <= '0;
            end else if (ld) begin
                r_cnt <= ld_val;
            end else if (inc) begin
                r_cnt  <= r_cnt + 1'b1;
                r_wrap <= &r_cnt;
            end
        end
    end

    assign cnt_q = r_cnt;
    assign wrap  = r_wrap;

endmodule

// File: rtl/cnt_arb_ctrl.sv
// Two-requester round-robin controller driving a shared counter.
// A granted command (op/arg) is latched and executed to completion;
// completion is signalled by a one-cycle registered ack to the grantee.
module cnt_arb_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [CNT_W-1:0] arg0,
    input  logic [CNT_W-1:0] arg1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_q,
    output logic             wrap
);

    state_e           r_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_arg;
    logic [CNT_W-1:0] r_rem;
    logic             r_prio;   // 1: requester 1 wins a tie, 0: requester 0 wins
    logic [1:0]       r_gnt;
    logic [1:0]       r_ack;
    logic             r_busy;

    logic [1:0]       w_elig;
    logic [1:0]       w_gnt;
    logic             w_pre;
    logic             w_clr;
    logic             w_ld;
    logic             w_inc;

    // A requester being acked this cycle sits out this arbitration round
    assign w_elig = req & ~r_ack;

    // Round-robin pick between eligible requesters
    always_comb begin
        w_gnt = 2'b00;
        if (w_elig == 2'b11) begin
            w_gnt = r_prio ? 2'b10 : 2'b01;
        end else begin
            w_gnt = w_elig;
        end
    end

    // Controller FSM: latch command on grant, execute, run remaining count, ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_arg   <= '0;
            r_rem   <= '0;
            r_prio  <= 1'b0;
            r_gnt   <= 2'b00;
            r_ack   <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_gnt   <= w_gnt;
                        r_op    <= op_e'(w_gnt[1] ? op1 : op0);
                        r_arg   <= w_gnt[1] ? arg1 : arg0;
                        r_prio  <= w_gnt[0];
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_COUNT && r_arg != '0) begin
                        r_rem   <= r_arg;
                        r_state <= ST_COUNT;
                    end else begin
                        r_ack   <= r_gnt;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        r_ack   <= r_gnt;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Counter controls come straight from the latched command and state
    assign w_pre = (r_state == ST_EXEC) && (r_op == OP_PRESET);
    assign w_clr = (r_state == ST_EXEC) && (r_op == OP_CLEAR);
    assign w_ld  = (r_state == ST_EXEC) && (r_op == OP_LOAD);
    assign w_inc = (r_state == ST_COUNT);

    cnt_reg #(.CNT_W(CNT_W)) u_cnt_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .pre    (w_pre),
        .clr    (w_clr),
        .ld     (w_ld),
        .inc    (w_inc),
        .ld_val (r_arg),
        .cnt_q  (cnt_q),
        .wrap   (wrap)
    );

    assign ack  = r_ack;
    assign busy = r_busy;

endmodule
